// File: rtl/counter_mod.sv
//==============================================================================
// Module   : counter_mod
// Purpose  : Programmable up/down event counter with wrap/saturate, load, clear,
//            registered terminal-count pulse and wrap-event counter.
//            Optional capture port set enabled by macro COUNTER_CAPTURE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_mod #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OVF_WIDTH  = 8,
  parameter int unsigned RST_VALUE  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic                  sat_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_val_i,
  input  logic [DATA_WIDTH-1:0] max_i,
`ifdef COUNTER_CAPTURE_EN
  input  logic                  capture_i,
  output logic [DATA_WIDTH-1:0] capt_o,
  output logic                  capt_valid_o,
`endif
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  tc_o,
  output logic [OVF_WIDTH-1:0]  wrap_cnt_o
);

  localparam logic [DATA_WIDTH-1:0] c_RST = DATA_WIDTH'(RST_VALUE);

  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_tc;
  logic [OVF_WIDTH-1:0]  r_wrap;

  logic                  w_term;
  logic                  w_wrap;
  logic [DATA_WIDTH-1:0] w_next;

  // Up counting terminates at or beyond max so loaded values above it still wrap.
  always_comb begin
    w_term = dir_i ? (r_count == '0) : (r_count >= max_i);
    w_wrap = w_term & ~sat_i;
    w_next = r_count;
    if (!w_term) begin
      w_next = dir_i ? (r_count - 1'b1) : (r_count + 1'b1);
    end else if (!sat_i) begin
      w_next = dir_i ? max_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= c_RST;
      r_tc    <= 1'b0;
      r_wrap  <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
      r_tc    <= 1'b0;
    end else if (en_i) begin
      r_count <= w_next;
      r_tc    <= w_term;
      if (w_wrap) begin
        r_wrap <= r_wrap + 1'b1;
      end
    end else begin
      r_tc    <= 1'b0;
    end
  end

`ifdef COUNTER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] r_capt;
  logic                  r_capt_valid;

  // Capture samples the pre-update count regardless of clear/load/step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_capt       <= '0;
      r_capt_valid <= 1'b0;
    end else begin
      r_capt_valid <= capture_i;
      if (capture_i) begin
        r_capt <= r_count;
      end
    end
  end

  assign capt_o       = r_capt;
  assign capt_valid_o = r_capt_valid;
`endif

  assign count_o    = r_count;
  assign tc_o       = r_tc;
  assign wrap_cnt_o = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_counter_mod.sv
//==============================================================================
// Module   : tb_counter_mod
// Purpose  : Table-driven self-checking bench for counter_mod (8-bit count,
//            2-bit wrap counter); capture checks when COUNTER_CAPTURE_EN is set.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_mod;

  localparam int DW = 8;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, clr_i = 1'b0, en_i = 1'b0, dir_i = 1'b0;
  logic          sat_i = 1'b0, load_i = 1'b0;
  logic [DW-1:0] load_val_i = '0, max_i = '0;
  logic [DW-1:0] count_o;
  logic          tc_o;
  logic [OW-1:0] wrap_cnt_o;
`ifdef COUNTER_CAPTURE_EN
  logic          capture_i = 1'b0;
  logic [DW-1:0] capt_o;
  logic          capt_valid_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_mod #(.DATA_WIDTH(DW), .OVF_WIDTH(OW), .RST_VALUE(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i), .dir_i(dir_i),
    .sat_i(sat_i), .load_i(load_i), .load_val_i(load_val_i), .max_i(max_i),
`ifdef COUNTER_CAPTURE_EN
    .capture_i(capture_i), .capt_o(capt_o), .capt_valid_o(capt_valid_o),
`endif
    .count_o(count_o), .tc_o(tc_o), .wrap_cnt_o(wrap_cnt_o)
  );

  typedef struct {
    logic          rst, clr, en, dir, sat, load;
    logic [DW-1:0] lv, mx;
    logic [DW-1:0] ec;
    logic          et;
    logic [OW-1:0] ew;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, clr, en, dir, sat, load,
                              input int lv, mx, ec, input logic et, input int ew);
    vec_t v;
    v.rst = rst; v.clr = clr; v.en = en; v.dir = dir; v.sat = sat; v.load = load;
    v.lv = DW'(lv); v.mx = DW'(mx); v.ec = DW'(ec); v.et = et; v.ew = OW'(ew);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst clr en dir sat ld  lv  mx  cnt tc wrap
    // T1: reset then up/wrap at max=4
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0,  4,  0, 0, 0));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  0,  4,  0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  1, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  2, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  3, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  4, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  4,  1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,  0,  4,  1, 0, 1));
    // T2: down/wrap at max=3 starting from 1
    vq.push_back(mk(0, 0, 0, 1, 0, 1,  1,  3,  1, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  3, 1, 2));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  2, 0, 2));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  1, 0, 2));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  0, 0, 2));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  3, 1, 3));
    // T3: clear beats enable, then saturate up at max=2
    vq.push_back(mk(0, 1, 1, 0, 1, 0,  0,  2,  0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0,  0,  2,  1, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0,  0,  2,  2, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0,  0,  2,  2, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0,  0,  2,  2, 1, 0));
    // T4: load above max beats enable, then wrap; load+clear -> clear wins
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 10,  5, 10, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  5,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  5,  1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 10,  5,  0, 0, 0));
    // T5: max=0 up/wrap, 2-bit wrap counter rolls over
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0, 1, 2));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0, 1, 3));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0, 1, 1));
    // Down from above max, down saturate at 0, idle, reset beats everything
    vq.push_back(mk(0, 0, 0, 1, 0, 1,  9,  3,  9, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 0, 0,  0,  3,  8, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 1, 1,  0,  3,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 1, 0,  0,  3,  0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 1, 0,  0,  3,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0,  0,  3,  1, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 1,  7,  3,  0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      rst_i = vq[i].rst; clr_i = vq[i].clr; en_i = vq[i].en; dir_i = vq[i].dir;
      sat_i = vq[i].sat; load_i = vq[i].load; load_val_i = vq[i].lv; max_i = vq[i].mx;
      tick();
      check($sformatf("v%0d count", i), int'(count_o),    int'(vq[i].ec));
      check($sformatf("v%0d tc", i),    int'(tc_o),       int'(vq[i].et));
      check($sformatf("v%0d wrap", i),  int'(wrap_cnt_o), int'(vq[i].ew));
    end

`ifdef COUNTER_CAPTURE_EN
    // T6: capture coincident with load, then clear keeps capture, reset drops it
    rst_i = 0; clr_i = 0; en_i = 0; load_i = 1; load_val_i = 7; capture_i = 0;
    tick();
    check("t6 preload", int'(count_o), 7);
    check("t6 valid idle", int'(capt_valid_o), 0);
    load_i = 1; load_val_i = 20; capture_i = 1;
    tick();
    check("t6 count", int'(count_o), 20);
    check("t6 capt", int'(capt_o), 7);
    check("t6 valid", int'(capt_valid_o), 1);
    load_i = 0; capture_i = 0; clr_i = 1;
    tick();
    check("t6 valid pulse", int'(capt_valid_o), 0);
    check("t6 capt after clr", int'(capt_o), 7);
    clr_i = 0; rst_i = 1;
    tick();
    check("t6 capt rst", int'(capt_o), 0);
    check("t6 valid rst", int'(capt_valid_o), 0);
    check("t6 count rst", int'(count_o), 0);
    rst_i = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
